// File: rtl/usr_deser.sv
// usr_deser: serial frame receiver (start bit 0, WIDTH data bits, stop bit 1).
// The received word sits in a holding register and is offered downstream
// on a valid/ready handshake. The block reports framing errors and overruns.
module usr_deser #(
    parameter int WIDTH = 5
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             SI,
    input  logic             bit_en,
    input  logic             msb_first,
    output logic [WIDTH-1:0] PO,
    output logic             valid,
    input  logic             ready,
    output logic             busy,
    output logic             frame_err,
    output logic             overrun
);

    // The counter must be able to hold WIDTH, because it increments past the last data bit.
    localparam int CW = $clog2(WIDTH + 1);

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        DATA = 2'd1,
        STOP = 2'd2
    } state_t;

    state_t           state_q, state_d;
    logic [WIDTH-1:0] sh_q, sh_d;
    logic [CW-1:0]    cnt_q, cnt_d;
    logic             dir_q, dir_d;
    logic [WIDTH-1:0] po_q, po_d;
    logic             valid_q, valid_d;
    logic             frame_err_q, frame_err_d;
    logic             overrun_q, overrun_d;
    logic             word_done;

    // Frame sequencing, shifting, and handshake/holding-register update.
    always_comb begin
        state_d     = state_q;
        sh_d        = sh_q;
        cnt_d       = cnt_q;
        dir_d       = dir_q;
        po_d        = po_q;
        valid_d     = valid_q;
        frame_err_d = 1'b0;
        overrun_d   = overrun_q;
        word_done   = 1'b0;

        case (state_q)
            IDLE: begin
                if (bit_en && !SI) begin
                    state_d = DATA;
                    cnt_d   = '0;
                    dir_d   = msb_first;
                end
            end
            DATA: begin
                if (bit_en) begin
                    if (dir_q) begin
                        sh_d = {sh_q[WIDTH-2:0], SI};
                    end else begin
                        sh_d = {SI, sh_q[WIDTH-1:1]};
                    end
                    cnt_d = cnt_q + CW'(1);
                    if (cnt_q == CW'(WIDTH - 1)) begin
                        state_d = STOP;
                    end
                end
            end
            STOP: begin
                // A 0 here is a framing error; it is never reused as a start bit.
                if (bit_en) begin
                    state_d = IDLE;
                    if (SI) begin
                        word_done = 1'b1;
                    end else begin
                        frame_err_d = 1'b1;
                    end
                end
            end
            default: begin
                state_d = IDLE;
            end
        endcase

        // A completed word loads only if the holding register is free or being
        // consumed in this same cycle; otherwise it is dropped and flagged.
        if (word_done) begin
            if (!valid_q || ready) begin
                po_d    = sh_q;
                valid_d = 1'b1;
            end else begin
                overrun_d = 1'b1;
            end
        end else if (valid_q && ready) begin
            valid_d = 1'b0;
        end
    end

    // State registers with asynchronous active-low clear.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state_q     <= IDLE;
            sh_q        <= '0;
            cnt_q       <= '0;
            dir_q       <= 1'b0;
            po_q        <= '0;
            valid_q     <= 1'b0;
            frame_err_q <= 1'b0;
            overrun_q   <= 1'b0;
        end else begin
            state_q     <= state_d;
            sh_q        <= sh_d;
            cnt_q       <= cnt_d;
            dir_q       <= dir_d;
            po_q        <= po_d;
            valid_q     <= valid_d;
            frame_err_q <= frame_err_d;
            overrun_q   <= overrun_d;
        end
    end

    assign PO        = po_q;
    assign valid     = valid_q;
    assign busy      = (state_q != IDLE);
    assign frame_err = frame_err_q;
    assign overrun   = overrun_q;

endmodule

// File: tb/tb_usr_deser.sv
// tb_usr_deser: directed-vector bench for usr_deser (WIDTH=5).
// Inputs are driven 1 time unit after each rising edge and outputs are checked there.
module tb_usr_deser;

    localparam int W = 5;

    logic         clk;
    logic         rst;
    logic         SI;
    logic         bit_en;
    logic         msb_first;
    logic [W-1:0] PO;
    logic         valid;
    logic         ready;
    logic         busy;
    logic         frame_err;
    logic         overrun;

    int tests_run;
    int tests_failed;

    usr_deser #(.WIDTH(W)) dut (
        .clk       (clk),
        .rst       (rst),
        .SI        (SI),
        .bit_en    (bit_en),
        .msb_first (msb_first),
        .PO        (PO),
        .valid     (valid),
        .ready     (ready),
        .busy      (busy),
        .frame_err (frame_err),
        .overrun   (overrun)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
        tests_run = tests_run + 1;
        if (got !== exp) begin
            tests_failed = tests_failed + 1;
            $display("[TB] FAIL %s: got %0h, expected %0h", tag, got, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    // One strobed sample of value v.
    task automatic strobe(input logic v);
        SI     = v;
        bit_en = 1'b1;
        tick();
        bit_en = 1'b0;
    endtask

    // Send a 7-symbol frame; seq[6] goes out first. gap = idle cycles between
    // strobes (SI scrambled during them), tgl = flip msb_first during data bits,
    // rdy_stop = raise ready on the stop-bit edge only.
    task automatic send_frame(input logic [6:0] seq, input logic dir, input int gap,
                              input logic tgl, input logic rdy_stop);
        msb_first = dir;
        for (int i = 0; i < 7; i++) begin
            if (tgl && i >= 1 && i <= 5) msb_first = ~msb_first;
            if (rdy_stop && i == 6) ready = 1'b1;
            strobe(seq[6-i]);
            ready = 1'b0;
            if (i == 0) check_eq("busy_after_start", {31'd0, busy}, 32'd1);
            if (i < 6) begin
                for (int g = 0; g < gap; g++) begin
                    SI = 1'($urandom_range(0, 1));
                    tick();
                end
            end
        end
        SI        = 1'b1;
        msb_first = dir;
        $display("[TB] frame seq=%b dir=%0d gap=%0d -> PO=%b valid=%0d ferr=%0d ovr=%0d",
                 seq, dir, gap, PO, valid, frame_err, overrun);
    endtask

    task automatic consume();
        ready = 1'b1;
        tick();
        ready = 1'b0;
        check_eq("valid_after_consume", {31'd0, valid}, 32'd0);
    endtask

    initial begin
        tests_run    = 0;
        tests_failed = 0;
        rst       = 1'b0;
        SI        = 1'b1;
        bit_en    = 1'b0;
        msb_first = 1'b1;
        ready     = 1'b0;
        repeat (3) @(posedge clk);
        #1;
        check_eq("rst_PO", {27'd0, PO}, 32'd0);
        check_eq("rst_valid", {31'd0, valid}, 32'd0);
        check_eq("rst_busy", {31'd0, busy}, 32'd0);
        check_eq("rst_frame_err", {31'd0, frame_err}, 32'd0);
        check_eq("rst_overrun", {31'd0, overrun}, 32'd0);
        rst = 1'b1;
        tick();

        // MSB-first, continuous strobes: 0,1,0,1,1,0,1 -> 10110
        send_frame(7'b0101101, 1'b1, 0, 1'b0, 1'b0);
        check_eq("msb_PO", {27'd0, PO}, 32'b10110);
        check_eq("msb_valid", {31'd0, valid}, 32'd1);
        check_eq("msb_busy", {31'd0, busy}, 32'd0);
        check_eq("msb_frame_err", {31'd0, frame_err}, 32'd0);
        consume();

        // LSB-first with msb_first toggling mid-frame: 0,0,1,1,0,1,1 -> 10110
        send_frame(7'b0011011, 1'b0, 0, 1'b1, 1'b0);
        check_eq("lsb_PO", {27'd0, PO}, 32'b10110);
        check_eq("lsb_valid", {31'd0, valid}, 32'd1);
        consume();

        // Strobe every 4th cycle, SI scrambled between strobes
        send_frame(7'b0101101, 1'b1, 3, 1'b0, 1'b0);
        check_eq("slow_PO", {27'd0, PO}, 32'b10110);
        check_eq("slow_valid", {31'd0, valid}, 32'd1);
        consume();

        // Bad stop bit
        send_frame(7'b0111110, 1'b1, 0, 1'b0, 1'b0);
        check_eq("bad_frame_err", {31'd0, frame_err}, 32'd1);
        check_eq("bad_valid", {31'd0, valid}, 32'd0);
        check_eq("bad_busy", {31'd0, busy}, 32'd0);
        check_eq("bad_PO_kept", {27'd0, PO}, 32'b10110);
        tick();
        check_eq("bad_frame_err_drop", {31'd0, frame_err}, 32'd0);
        check_eq("bad_not_restart", {31'd0, busy}, 32'd0);
        send_frame(7'b0000111, 1'b1, 0, 1'b0, 1'b0);
        check_eq("after_bad_PO", {27'd0, PO}, 32'b00011);
        check_eq("after_bad_valid", {31'd0, valid}, 32'd1);
        consume();

        // Overrun: two words with ready low
        send_frame(7'b0000011, 1'b1, 0, 1'b0, 1'b0);
        check_eq("ovr_first_overrun", {31'd0, overrun}, 32'd0);
        send_frame(7'b0111111, 1'b1, 0, 1'b0, 1'b0);
        check_eq("ovr_PO", {27'd0, PO}, 32'b00001);
        check_eq("ovr_valid", {31'd0, valid}, 32'd1);
        check_eq("ovr_overrun", {31'd0, overrun}, 32'd1);
        consume();
        check_eq("ovr_sticky", {31'd0, overrun}, 32'd1);

        // Reset clears sticky overrun; then ready exactly on second stop edge
        rst = 1'b0;
        tick();
        check_eq("rst2_overrun", {31'd0, overrun}, 32'd0);
        rst = 1'b1;
        tick();
        send_frame(7'b0000011, 1'b1, 0, 1'b0, 1'b0);
        send_frame(7'b0111111, 1'b1, 0, 1'b0, 1'b1);
        check_eq("swap_PO", {27'd0, PO}, 32'b11111);
        check_eq("swap_valid", {31'd0, valid}, 32'd1);
        check_eq("swap_overrun", {31'd0, overrun}, 32'd0);

        // Async reset after the 3rd data bit, with a word still pending
        msb_first = 1'b1;
        strobe(1'b0);
        strobe(1'b1);
        strobe(1'b0);
        strobe(1'b1);
        check_eq("pre_arst_busy", {31'd0, busy}, 32'd1);
        #2;
        rst = 1'b0;
        #1;
        check_eq("arst_PO", {27'd0, PO}, 32'd0);
        check_eq("arst_valid", {31'd0, valid}, 32'd0);
        check_eq("arst_busy", {31'd0, busy}, 32'd0);
        check_eq("arst_overrun", {31'd0, overrun}, 32'd0);
        $display("[TB] async reset mid-frame -> PO=%b valid=%0d busy=%0d", PO, valid, busy);
        tick();
        rst = 1'b1;
        tick();
        send_frame(7'b0010101, 1'b1, 0, 1'b0, 1'b0);
        check_eq("post_rst_PO", {27'd0, PO}, 32'b01010);
        check_eq("post_rst_valid", {31'd0, valid}, 32'd1);
        consume();

        $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
        $finish;
    end

endmodule

// File: doc/usr_deser.md
# usr_deser

Serial-to-parallel frame receiver that terminates the serial output of the team's universal shift register when that register runs as a transmitter. Each frame on the line carries:

- a start bit (0);
- WIDTH data bits, MSB-first or LSB-first, matching the shift-left and shift-right register modes;
- a stop bit (1).

The block deserializes each frame into a holding register and offers the word downstream on a valid/ready handshake. It reports framing errors and overruns.

## Interface

- WIDTH, 5, data bits per frame (≥2).
- clk  input  1  system clock, all state on rising edge.
- rst  input  1  reset, asynchronous, active-low; clears all state immediately.
- SI  input  1  serial data line, idle high.
- bit_en  input  1  bit strobe; SI is sampled only on cycles with bit_en=1.
- msb_first  input  1  1 = first data bit is word MSB, 0 = first data bit is LSB; captured at start bit.
- PO  output  WIDTH  received word (holding register).
- valid  output  1  PO holds an unconsumed word.
- ready  input  1  downstream accepts PO when valid&&ready at a rising edge.
- busy  output  1  frame in progress (state ≠ IDLE).
- frame_err  output  1  one-cycle pulse: stop bit sampled as 0.
- overrun  output  1  sticky: a good frame completed while a word was still pending; cleared only by reset.

## Operation

- States: IDLE, DATA, STOP. Shift register sh[WIDTH-1:0], bit counter cnt, and a captured direction bit dir.
- IDLE:
  - bit_en && SI==0 → DATA; cnt←0; dir←msb_first.
  - bit_en && SI==1, or no bit_en → stay in IDLE.
- DATA, on each bit_en:
  - dir=1: sh←{sh[WIDTH-2:0],SI}.
  - dir=0: sh←{SI,sh[WIDTH-1:1]}.
  - cnt←cnt+1.
  - On the WIDTH-th data bit → STOP.
- STOP, on bit_en:
  - SI==1 → word complete; return to IDLE.
  - SI==0 → frame_err=1 for one cycle; sh discarded; return to IDLE. This 0 is not reinterpreted as a new start bit.
- Word complete, no pending word (valid=0, or valid&&ready in the same cycle): PO←sh, valid←1.
- Word complete, valid=1 && ready=0: new word dropped, PO unchanged, overrun←1.
- No completion: valid&&ready → valid←0. PO retains its last value.
- bit_en=0 cycles: state, sh, and cnt hold. There is no timeout.
- msb_first changes mid-frame are ignored; dir applies to the whole frame.
- Reset mid-frame: the frame is abandoned and the block returns to IDLE with all outputs at reset values.

## Timing

- Reset values: PO=0, valid=0, busy=0, frame_err=0, overrun=0, state=IDLE, sh=0, cnt=0.
- busy=1 from the edge that samples the start bit until the edge that samples the stop bit.
- Latency: valid rises on the clock edge that samples the stop bit with bit_en=1. It is visible the cycle after the stop-bit sample, and PO is valid in the same cycle.
- Minimum frame length is WIDTH+2 bit_en strobes. Back-to-back frames are supported: a start bit may be strobed on the cycle directly after the stop-bit sample.
- frame_err is registered. It is high exactly one cycle, the cycle after the bad stop sample.
- Handshake: valid stays high until it is consumed. PO is stable while valid=1.
- Simultaneous completion and valid&&ready: the old word is consumed, the new word is loaded, valid stays 1, and overrun is not set.

## Test plan

- Reset, then WIDTH=5, msb_first=1, bit_en continuous, SI sequence 0,1,0,1,1,0,1 → PO=5'b10110, valid=1 the cycle after the stop bit, busy low again, frame_err=0.
- msb_first=0, SI sequence 0,0,1,1,0,1,1 → PO=5'b10110. Toggling msb_first during data bits does not change the result.
- bit_en asserted every 4th cycle with the first frame's bit pattern, SI changing between strobes → same PO=5'b10110. Only strobed samples matter.
- Bad stop: 0,1,1,1,1,1,0 → frame_err pulses one cycle, valid stays 0, state IDLE. A following good frame for 5'b00011 is received correctly.
- With ready=0, receive 5'b00001 then 5'b11111 → PO=5'b00001, overrun=1. Then ready=1 → valid drops. Repeat with ready=1 exactly on the second stop-bit edge → PO=5'b11111, valid stays 1, overrun not newly set.
- Assert rst low asynchronously after the 3rd data bit → all outputs zero immediately. After release, a full frame for 5'b01010 is received correctly.
